// File: rtl/dma_channel.sv
// Single DMA channel: copies halfwords/words from src to dst over the shared mem bus.
// Arming, start timing, repeat reload and completion IRQ follow the SAD/DAD/CNT register model.
module dma_channel #(
  parameter int unsigned COUNT_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cfg_src,
  input  logic [31:0]        cfg_dst,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic [15:0]        cfg_ctrl,
  input  logic               cfg_ctrl_write,
  input  logic               vblank_pulse,
  input  logic               hblank_pulse,
  output logic               active,
  output logic               irq,
  output logic               bus_req,
  input  logic               bus_gnt,
  inout  logic [31:0]        mem_addr,
  inout  logic [31:0]        mem_data,
  output logic [1:0]         mem_width,
  output logic               mem_read,
  output logic               mem_write,
  input  logic               ok
);

  typedef enum logic [2:0] {IDLE, ARMED, REQ, RD, WR, STEP, DONE} state_t;

  state_t           state;
  logic [31:0]      src, dst, buffer;
  logic [COUNT_W:0] count;
  logic [1:0]       dst_ctl, src_ctl, timing;
  logic             rpt, word, irq_en;
  logic             acc_second, abort_pend;

  logic        own, trig, abort_req, cfg_en_write;
  logic [31:0] wdata;
  logic        unused_ctrl;

  function automatic logic [31:0] align(input logic [31:0] a, input logic w);
    return w ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
  endfunction

  function automatic logic [COUNT_W:0] load_count(input logic [COUNT_W-1:0] c);
    logic [COUNT_W:0] r;
    r = {1'b0, c};
    if (c == '0) r[COUNT_W] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] ctl,
                                            input logic w, input logic is_src);
    logic [31:0] delta;
    delta = w ? 32'd4 : 32'd2;
    case (ctl)
      2'd0:    return a + delta;
      2'd1:    return a - delta;
      2'd2:    return a;
      default: return is_src ? a : a + delta;
    endcase
  endfunction

  assign own          = (state == RD || state == WR) && bus_gnt;
  assign abort_req    = cfg_ctrl_write && !cfg_ctrl[15];
  assign cfg_en_write = cfg_ctrl_write && cfg_ctrl[15];
  assign trig         = (timing == 2'd0) || (timing == 2'd1 && vblank_pulse) ||
                        (timing == 2'd2 && hblank_pulse);
  assign wdata        = word ? buffer : {buffer[15:0], buffer[15:0]};
  assign unused_ctrl  = ^{cfg_ctrl[4:0], cfg_ctrl[11]};

  // Bus-facing outputs are gated by the grant so a lost grant releases the bus at once.
  assign mem_read  = own && state == RD;
  assign mem_write = own && state == WR;
  assign mem_width = own ? (word ? 2'd2 : 2'd1) : 2'd0;
  assign mem_addr  = own ? ((state == RD) ? src : dst) : 'z;
  assign mem_data  = (own && state == WR) ? wdata : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      buffer     <= '0;
      count      <= '0;
      dst_ctl    <= '0;
      src_ctl    <= '0;
      timing     <= '0;
      rpt        <= 1'b0;
      word       <= 1'b0;
      irq_en     <= 1'b0;
      acc_second <= 1'b0;
      abort_pend <= 1'b0;
      active     <= 1'b0;
      irq        <= 1'b0;
      bus_req    <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (cfg_en_write) begin
        dst_ctl <= cfg_ctrl[6:5];
        src_ctl <= cfg_ctrl[8:7];
        rpt     <= cfg_ctrl[9];
        word    <= cfg_ctrl[10];
        timing  <= cfg_ctrl[13:12];
        irq_en  <= cfg_ctrl[14];
      end
      unique case (state)
        IDLE: begin
          if (cfg_en_write) begin
            src    <= align(cfg_src, cfg_ctrl[10]);
            dst    <= align(cfg_dst, cfg_ctrl[10]);
            count  <= load_count(cfg_count);
            active <= 1'b1;
            state  <= ARMED;
          end
        end
        ARMED: begin
          if (abort_req) begin
            active <= 1'b0;
            state  <= IDLE;
          end else if (trig) begin
            bus_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          bus_req <= 1'b1;
          if (abort_req) begin
            active  <= 1'b0;
            bus_req <= 1'b0;
            state   <= IDLE;
          end else if (bus_gnt) begin
            acc_second <= 1'b0;
            state      <= RD;
          end
        end
        RD, WR: begin
          if (abort_req) abort_pend <= 1'b1;
          if (!own) begin
            acc_second <= 1'b0;
          end else if (!acc_second) begin
            acc_second <= 1'b1;
          end else if (ok) begin
            acc_second <= 1'b0;
            if (state == RD) begin
              buffer <= word ? mem_data : {16'h0000, mem_data[15:0]};
              state  <= WR;
            end else if (abort_pend || abort_req) begin
              abort_pend <= 1'b0;
              active     <= 1'b0;
              bus_req    <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          src   <= step_addr(src, src_ctl, word, 1'b1);
          dst   <= step_addr(dst, dst_ctl, word, 1'b0);
          count <= count - 1'b1;
          if (abort_req) begin
            active  <= 1'b0;
            bus_req <= 1'b0;
            state   <= IDLE;
          end else if (count == {{COUNT_W{1'b0}}, 1'b1}) begin
            bus_req <= 1'b0;
            irq     <= irq_en;
            state   <= DONE;
          end else begin
            state <= RD;
          end
        end
        DONE: begin
          if (!abort_req && rpt && timing != 2'd0) begin
            count <= load_count(cfg_count);
            if (dst_ctl == 2'd3) dst <= align(cfg_dst, word);
            state <= ARMED;
          end else begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel.sv
// Scoreboard bench for dma_channel: expected bus accesses are queued by the stimulus
// and popped by a monitor whenever an access completes on the mem bus.
module tb_dma_channel;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_src = '0, cfg_dst = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [15:0]   cfg_ctrl = '0;
  logic          cfg_ctrl_write = 1'b0;
  logic          vblank_pulse = 1'b0, hblank_pulse = 1'b0;
  logic          bus_gnt = 1'b1, ok = 1'b1;
  logic          active, irq, bus_req, mem_read, mem_write;
  logic [1:0]    mem_width;
  wire  [31:0]   mem_addr, mem_data;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data;
  } xact_t;

  xact_t exp_q[$];
  int    errors = 0, checks = 0, irq_cnt = 0, n_writes = 0, hold = 0;
  logic [31:0] held_addr = '0;

  dma_channel #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count),
    .cfg_ctrl(cfg_ctrl), .cfg_ctrl_write(cfg_ctrl_write), .vblank_pulse(vblank_pulse),
    .hblank_pulse(hblank_pulse), .active(active), .irq(irq), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .mem_addr(mem_addr), .mem_data(mem_data), .mem_width(mem_width),
    .mem_read(mem_read), .mem_write(mem_write), .ok(ok)
  );

  always #5 clk = ~clk;

  // Memory returns a pattern whose low half is the low half of the address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign mem_data = mem_read ? pat(mem_addr) : 32'bz;

  always @(negedge clk) if (!rst && irq) irq_cnt++;

  always @(negedge clk) begin
    xact_t act, e;
    if (!rst && (mem_read || mem_write)) begin
      hold++;
      if (hold > 1) begin
        checks++;
        if (mem_addr !== held_addr) begin
          errors++;
          $display("FAIL addr_stable: got %h required %h", mem_addr, held_addr);
        end
      end
      held_addr = mem_addr;
      if (hold >= 2 && ok) begin
        act = '{mem_write, mem_addr, mem_width, mem_write ? mem_data : 32'h0};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: got %h required none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL bus_access: got wr=%0b addr=%h w=%0d data=%h required wr=%0b addr=%h w=%0d data=%h",
                     act.wr, act.addr, act.width, act.data, e.wr, e.addr, e.width, e.data);
          end
        end
        if (mem_write) n_writes++;
        hold = 0;
      end
    end else begin
      hold = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_elem(input logic [31:0] s, input logic [31:0] d, input logic w);
    logic [31:0] p;
    p = pat(s);
    exp_q.push_back('{1'b0, s, w ? 2'd2 : 2'd1, 32'h0});
    exp_q.push_back('{1'b1, d, w ? 2'd2 : 2'd1, w ? p : {p[15:0], p[15:0]}});
  endtask

  task automatic cfg_write(input logic [31:0] s, input logic [31:0] d,
                           input logic [CW-1:0] c, input logic [15:0] ctl);
    cfg_src = s; cfg_dst = d; cfg_count = c; cfg_ctrl = ctl;
    cfg_ctrl_write = 1'b1;
    tick();
    cfg_ctrl_write = 1'b0;
  endtask

  task automatic cfg_ctrl_only(input logic [15:0] ctl);
    cfg_ctrl = ctl;
    cfg_ctrl_write = 1'b1;
    tick();
    cfg_ctrl_write = 1'b0;
  endtask

  task automatic wait_inactive(input string name, input int budget);
    int n = 0;
    while (active && n < budget) begin tick(); n++; end
    check(name, {63'b0, active}, 64'd0);
  endtask

  task automatic wait_write_at(input string name, input logic [31:0] a, input int budget);
    int n = 0;
    while (!(mem_write && mem_addr == a) && n < budget) begin tick(); n++; end
    check(name, {31'b0, mem_write, mem_addr}, {31'b0, 1'b1, a});
  endtask

  task automatic wait_read_at(input string name, input logic [31:0] a, input int budget);
    int n = 0;
    while (!(mem_read && mem_addr == a) && n < budget) begin tick(); n++; end
    check(name, {31'b0, mem_read, mem_addr}, {31'b0, 1'b1, a});
  endtask

  task automatic wait_bus_req(input string name, input logic v, input int budget);
    int n = 0;
    while (bus_req != v && n < budget) begin tick(); n++; end
    check(name, {63'b0, bus_req}, {63'b0, v});
  endtask

  function automatic logic [63:0] out_vec();
    return {57'b0, active, irq, bus_req, mem_read, mem_write, mem_width};
  endfunction

  initial begin
    int wr0;
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wr0;
    tick(); tick();
    check("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_outputs", out_vec(), 64'd0);

    // Immediate word copy, count 4
    for (int i = 0; i < 4; i++)
      push_elem(32'h0300_0000 + 32'(4 * i), 32'h0200_0100 + 32'(4 * i), 1'b1);
    cfg_write(32'h0300_0000, 32'h0200_0100, 4'd4, 16'h8400);
    check("armed_active", {63'b0, active}, 64'd1);
    wait_inactive("t1_done", 60);
    tick(); tick();
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_no_irq", 64'(irq_cnt), 64'd0);
    check("t1_idle_outputs", out_vec(), 64'd0);

    // Halfword, src decrement, dst fixed; misaligned src is forced to 0x...06
    push_elem(32'h0300_0006, 32'h0200_0200, 1'b0);
    push_elem(32'h0300_0004, 32'h0200_0200, 1'b0);
    push_elem(32'h0300_0002, 32'h0200_0200, 1'b0);
    cfg_write(32'h0300_0007, 32'h0200_0200, 4'd3, 16'h80C0);
    wait_inactive("t2_done", 60);
    tick();
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Memory stall: ok low for three extra cycles in the write
    push_elem(32'h0300_0010, 32'h0200_0300, 1'b1);
    cfg_write(32'h0300_0010, 32'h0200_0300, 4'd1, 16'h8400);
    wait_write_at("t3_wr_start", 32'h0200_0300, 20);
    ok = 1'b0;
    repeat (4) tick();
    check("t3_stall_held", {31'b0, mem_write, mem_addr}, {31'b0, 1'b1, 32'h0200_0300});
    ok = 1'b1;
    wait_inactive("t3_done", 20);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Repeat on hblank with dst reload, irq per burst
    irq_cnt = 0;
    cfg_write(32'h0300_0020, 32'h0200_0400, 4'd2, 16'hE660);
    vblank_pulse = 1'b1; tick(); vblank_pulse = 1'b0;
    repeat (3) tick();
    check("t4_vblank_ignored", {62'b0, active, bus_req}, {62'b0, 1'b1, 1'b0});
    push_elem(32'h0300_0020, 32'h0200_0400, 1'b1);
    push_elem(32'h0300_0024, 32'h0200_0404, 1'b1);
    hblank_pulse = 1'b1; tick(); hblank_pulse = 1'b0;
    wait_bus_req("t4_req1", 1'b1, 10);
    wait_bus_req("t4_rel1", 1'b0, 60);
    tick(); tick();
    check("t4_burst1", {32'(irq_cnt), 31'b0, active}, {32'd1, 31'b0, 1'b1});
    check("t4_q1_empty", 64'(exp_q.size()), 64'd0);
    push_elem(32'h0300_0028, 32'h0200_0400, 1'b1);
    push_elem(32'h0300_002C, 32'h0200_0404, 1'b1);
    hblank_pulse = 1'b1; tick(); hblank_pulse = 1'b0;
    wait_bus_req("t4_req2", 1'b1, 10);
    wait_bus_req("t4_rel2", 1'b0, 60);
    tick(); tick();
    check("t4_burst2", {32'(irq_cnt), 31'b0, active}, {32'd2, 31'b0, 1'b1});
    check("t4_q2_empty", 64'(exp_q.size()), 64'd0);
    cfg_ctrl_only(16'h0000);
    check("t4_abort_armed", out_vec(), 64'd0);

    // Abort during the read of element 2 of 5: element 2 still completes, no irq
    irq_cnt = 0;
    push_elem(32'h0300_0040, 32'h0200_0500, 1'b1);
    push_elem(32'h0300_0044, 32'h0200_0504, 1'b1);
    cfg_write(32'h0300_0040, 32'h0200_0500, 4'd5, 16'hC400);
    wait_read_at("t5_rd2", 32'h0300_0044, 30);
    cfg_ctrl_only(16'h0000);
    wait_inactive("t5_aborted", 20);
    tick(); tick();
    check("t5_outputs", out_vec(), 64'd0);
    check("t5_no_irq", 64'(irq_cnt), 64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // count 0 means 16 units; grant dropped in the first write
    for (int i = 0; i < 16; i++)
      push_elem(32'h0300_0100 + 32'(4 * i), 32'h0200_0600 + 32'(4 * i), 1'b1);
    wr0 = n_writes;
    cfg_write(32'h0300_0100, 32'h0200_0600, 4'd0, 16'h8400);
    wait_write_at("t6_wr1", 32'h0200_0600, 20);
    bus_gnt = 1'b0;
    tick();
    check("t6_gnt_drop", {61'b0, mem_write, mem_width}, 64'd0);
    tick();
    bus_gnt = 1'b1;
    wait_inactive("t6_done", 300);
    check("t6_write_count", 64'(n_writes - wr0), 64'd16);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a burst
    push_elem(32'h0300_0200, 32'h0200_0700, 1'b1);
    exp_q.push_back('{1'b0, 32'h0300_0204, 2'd2, 32'h0});
    cfg_write(32'h0300_0200, 32'h0200_0700, 4'd5, 16'hC400);
    wait_write_at("t7_wr2", 32'h0200_0704, 30);
    rst = 1'b1;
    tick();
    check("t7_reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("t7_stays_idle", out_vec(), 64'd0);
    check("t7_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
